// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-code values, op width and
// the controller state encoding.
package alu_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [OP_W-1:0] ALU_OR   = 4'd2;
   localparam logic [OP_W-1:0] ALU_AND  = 4'd3;
   localparam logic [OP_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [OP_W-1:0] ALU_NOR  = 4'd5;
   localparam logic [OP_W-1:0] ALU_SLT  = 4'd6;
   localparam logic [OP_W-1:0] ALU_SLTU = 4'd7;
   localparam logic [OP_W-1:0] ALU_SLL  = 4'd8;
   localparam logic [OP_W-1:0] ALU_SRL  = 4'd9;
   localparam logic [OP_W-1:0] ALU_SRA  = 4'd10;
   localparam logic [OP_W-1:0] ALU_MUL  = 4'd11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Codes above MUL have no operation assigned to them.
   function automatic logic op_is_legal(input logic [OP_W-1:0] code);
      return code <= ALU_MUL;
   endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add unsigned multiplier. One multiplier bit is consumed per
// step; after WIDTH steps {acc, multiplier} holds the full 2*WIDTH product.
// The next-step product is exported so the top can register it on the last step.
module seq_alu_mul #(
   parameter int WIDTH = 32,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] prod_hi_next,
   output logic [WIDTH-1:0] prod_lo_next
);

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic [CW-1:0]    count;
   logic [WIDTH:0]   partial;

   // Add the multiplicand when the current multiplier bit is set, then shift
   // the whole {acc, multiplier} pair right by one, keeping the carry.
   always_comb begin
      partial      = {1'b0, acc} + (multiplier[0] ? {1'b0, multiplicand} : '0);
      prod_hi_next = partial[WIDTH:1];
      prod_lo_next = {partial[0], multiplier[WIDTH-1:1]};
      last         = (count == CW'(1));
   end

   // Capture operands on load, otherwise advance one bit per step.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc          <= '0;
         multiplicand <= '0;
         multiplier   <= '0;
         count        <= '0;
      end else if (load) begin
         acc          <= '0;
         multiplicand <= a;
         multiplier   <= b;
         count        <= CW'(WIDTH);
      end else if (step) begin
         acc          <= prod_hi_next;
         multiplier   <= prod_lo_next;
         count        <= count - CW'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with start/done handshake. Single-cycle ops complete on the
// accepting edge; MUL runs through the iterative multiplier for WIDTH edges.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             overflow,
   output logic             illegal
);

   state_t           state;
   state_t           state_next;
   logic             mul_load;
   logic             mul_step;
   logic             mul_last;
   logic             mul_finish;
   logic             alu_fire;
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             alu_ill;
   logic [WIDTH-1:0] add_res;
   logic [WIDTH-1:0] sub_res;
   logic [WIDTH-1:0] b_neg;
   logic [SHW-1:0]   shamt;

   seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk          (clk),
      .rst          (rst),
      .load         (mul_load),
      .step         (mul_step),
      .a            (a),
      .b            (b),
      .last         (mul_last),
      .prod_hi_next (mul_hi),
      .prod_lo_next (mul_lo)
   );

   // State register; reset aborts any multiply in flight.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next state: only a MUL request leaves IDLE, the last step returns.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start && op == ALU_MUL) state_next = ST_MUL;
         ST_MUL:  if (mul_last)               state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Control outputs: start is only looked at while idle, so no queueing.
   always_comb begin
      busy       = (state == ST_MUL);
      mul_load   = (state == ST_IDLE) && start && (op == ALU_MUL);
      alu_fire   = (state == ST_IDLE) && start && (op != ALU_MUL);
      mul_step   = (state == ST_MUL);
      mul_finish = (state == ST_MUL) && mul_last;
   end

   // Single-cycle operation mux and signed-overflow detection.
   always_comb begin
      add_res = a + b;
      sub_res = a - b;
      b_neg   = ~b + WIDTH'(1);
      shamt   = b[SHW-1:0];
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = !op_is_legal(op);
      case (op)
         ALU_ADD: begin
            alu_res = add_res;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res = sub_res;
            alu_ovf = (a[WIDTH-1] == b_neg[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_OR:   alu_res = a | b;
         ALU_AND:  alu_res = a & b;
         ALU_XOR:  alu_res = a ^ b;
         ALU_NOR:  alu_res = ~(a | b);
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
         ALU_SLL:  alu_res = a << shamt;
         ALU_SRL:  alu_res = a >> shamt;
         ALU_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
         default:  alu_res = '0;
      endcase
   end

   // Output registers: written only on completion, otherwise they hold.
   // done and illegal are one-cycle pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         done      <= 1'b0;
         illegal   <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         if (alu_fire) begin
            done      <= 1'b1;
            illegal   <= alu_ill;
            result    <= alu_res;
            result_hi <= '0;
            zero      <= (alu_res == '0);
            overflow  <= alu_ovf;
         end else if (mul_finish) begin
            done      <= 1'b1;
            result    <= mul_lo;
            result_hi <= mul_hi;
            zero      <= (mul_lo == '0);
            overflow  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_seq_alu;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   op = 4'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         zero;
   logic         overflow;
   logic         illegal;

   int checks = 0;
   int failures = 0;

   seq_alu #(.WIDTH(W), .SHW(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .result_hi (result_hi),
      .zero      (zero),
      .overflow  (overflow),
      .illegal   (illegal)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Reference model straight from the operation definitions.
   function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic [W-1:0] hi,
                                 output logic z, output logic ov, output logic ill);
      logic [2*W-1:0] prod;
      logic [W-1:0]   yp;
      int             sh;
      sh  = int'(y % W);
      hi  = '0;
      ov  = 1'b0;
      ill = 1'b0;
      r   = '0;
      case (o)
         4'd0:  begin r = x + y; ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]); end
         4'd1:  begin r = x - y; yp = -y; ov = (x[W-1] == yp[W-1]) && (r[W-1] != x[W-1]); end
         4'd2:  r = x | y;
         4'd3:  r = x & y;
         4'd4:  r = x ^ y;
         4'd5:  r = ~(x | y);
         4'd6:  r = ($signed(x) < $signed(y)) ? 1 : 0;
         4'd7:  r = (x < y) ? 1 : 0;
         4'd8:  r = x << sh;
         4'd9:  r = x >> sh;
         4'd10: r = W'($signed(x) >>> sh);
         4'd11: begin prod = 64'(x) * 64'(y); r = prod[W-1:0]; hi = prod[2*W-1:W]; end
         default: ill = 1'b1;
      endcase
      z = (r == '0);
   endfunction

   // Issue one request and wait (bounded) for done; edges counts clock
   // edges after the accepting edge until done was seen.
   task automatic exec_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int edges);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 0;
      while (done !== 1'b1 && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; op = 4'd0; a = 32'd5; b = 32'd7;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      checks++; if (result !== '0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      start = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, done, result, result_hi, zero, overflow, illegal} !== '0) begin
         failures++;
         $display("[TB] FAIL idle_outputs: got busy=%b done=%b res=%h hi=%h z=%b ov=%b ill=%b expected all 0",
                  busy, done, result, result_hi, zero, overflow, illegal);
      end
   endtask

   task automatic test_arith();
      int e;
      exec_op(4'd0, 32'h7FFFFFFF, 32'd1, e);
      checks++; if (e !== 0) begin failures++; $display("[TB] FAIL add_latency: got %0d expected 0", e); end
      checks++; if (result !== 32'h80000000) begin failures++; $display("[TB] FAIL add_result: got %h expected 80000000", result); end
      checks++; if (overflow !== 1'b1 || zero !== 1'b0) begin failures++; $display("[TB] FAIL add_flags: got ov=%b z=%b expected ov=1 z=0", overflow, zero); end
      exec_op(4'd1, 32'd5, 32'd5, e);
      checks++; if (result !== '0 || zero !== 1'b1 || overflow !== 1'b0) begin failures++; $display("[TB] FAIL sub_zero: got res=%h z=%b ov=%b expected 0 1 0", result, zero, overflow); end
      exec_op(4'd6, 32'hFFFFFFFF, 32'd1, e);
      checks++; if (result !== 32'd1) begin failures++; $display("[TB] FAIL slt: got %h expected 1", result); end
      exec_op(4'd7, 32'hFFFFFFFF, 32'd1, e);
      checks++; if (result !== 32'd0) begin failures++; $display("[TB] FAIL sltu: got %h expected 0", result); end
      exec_op(4'd10, 32'h80000000, 32'h24, e);
      checks++; if (result !== 32'hF8000000) begin failures++; $display("[TB] FAIL sra: got %h expected f8000000", result); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_mul();
      int edges;
      int busy_cycles;
      start = 1'b1; op = 4'd11; a = 32'hFFFFFFFF; b = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      edges = 0;
      busy_cycles = 0;
      while (done !== 1'b1 && edges < 100) begin
         if (busy === 1'b1) busy_cycles++;
         if (edges == 5) begin start = 1'b1; op = 4'd0; a = 32'd1; b = 32'd1; end
         if (edges == 7) begin start = 1'b0; a = 32'h1234; b = 32'h5678; end
         @(posedge clk); #1;
         edges++;
      end
      checks++; if (edges !== W) begin failures++; $display("[TB] FAIL mul_latency: got %0d expected %0d", edges, W); end
      checks++; if (busy_cycles !== W) begin failures++; $display("[TB] FAIL mul_busy: got %0d expected %0d", busy_cycles, W); end
      checks++; if (result !== 32'hFFFFFFFE || result_hi !== 32'd1) begin failures++; $display("[TB] FAIL mul_result: got %h_%h expected 00000001_fffffffe", result_hi, result); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mul_busy_end: got %b expected 0", busy); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || result !== 32'hFFFFFFFE) begin failures++; $display("[TB] FAIL mul_no_queue: got done=%b res=%h expected 0 fffffffe", done, result); end
   endtask

   task automatic test_back_to_back();
      int e;
      exec_op(4'd11, 32'd3, 32'd7, e);
      checks++; if (done !== 1'b1 || result !== 32'd21) begin failures++; $display("[TB] FAIL b2b_mul: got done=%b res=%h expected 1 15", done, result); end
      start = 1'b1; op = 4'd0; a = 32'd100; b = 32'd23;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (done !== 1'b1 || result !== 32'd123 || result_hi !== '0) begin failures++; $display("[TB] FAIL b2b_add: got done=%b res=%h hi=%h expected 1 7b 0", done, result, result_hi); end
   endtask

   task automatic test_illegal();
      int e;
      exec_op(4'd13, $urandom, $urandom, e);
      checks++;
      if (e !== 0 || illegal !== 1'b1 || result !== '0 || result_hi !== '0 || zero !== 1'b1 || overflow !== 1'b0) begin
         failures++;
         $display("[TB] FAIL illegal_op: got lat=%0d ill=%b res=%h hi=%h z=%b ov=%b expected 0 1 0 0 1 0",
                  e, illegal, result, result_hi, zero, overflow);
      end
      @(posedge clk); #1;
      checks++; if (illegal !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL illegal_pulse: got ill=%b done=%b expected 0 0", illegal, done); end
   endtask

   task automatic test_random_ops();
      int e;
      logic [3:0]   o;
      logic [W-1:0] x, y, er, eh;
      logic         ez, eov, eill;
      for (int i = 0; i < 40; i++) begin
         o = 4'($urandom_range(0, 15));
         x = $urandom;
         y = $urandom;
         if (i % 8 == 1) x = 32'h80000000;
         if (i % 8 == 2) y = 32'h7FFFFFFF;
         if (i % 8 == 3) y = x;
         model(o, x, y, er, eh, ez, eov, eill);
         exec_op(o, x, y, e);
         checks++;
         if (e !== ((o == 4'd11) ? W : 0) || result !== er || result_hi !== eh ||
             zero !== ez || overflow !== eov || illegal !== eill) begin
            failures++;
            $display("[TB] FAIL random_op%0d: op=%0d a=%h b=%h got lat=%0d res=%h hi=%h z=%b ov=%b ill=%b expected lat=%0d res=%h hi=%h z=%b ov=%b ill=%b",
                     i, o, x, y, e, result, result_hi, zero, overflow, illegal,
                     (o == 4'd11) ? W : 0, er, eh, ez, eov, eill);
         end
      end
   endtask

   task automatic test_reset_mid_mul();
      int seen_done;
      start = 1'b1; op = 4'd11; a = $urandom | 32'h1; b = $urandom | 32'h1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || result_hi !== '0) begin
         failures++;
         $display("[TB] FAIL reset_mid_mul: got busy=%b done=%b res=%h hi=%h expected 0 0 0 0", busy, done, result, result_hi);
      end
      seen_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) seen_done++;
      end
      checks++; if (seen_done !== 0) begin failures++; $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", seen_done); end
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_arith();
      test_mul();
      test_back_to_back();
      test_illegal();
      test_random_ops();
      test_reset_mid_mul();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
